// File: rtl/mult_pkg.sv
// Shared types and width helpers for the sequential shift-add multiplier.
package mult_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam int unsigned DefaultWidth = 4;

  // Bit counter must be able to hold the value WIDTH itself.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/sign_mag.sv
// Combinational conditional two's-complement negate; used for both abs and result negation.
module sign_mag
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic [WIDTH-1:0] a,
  input  logic             neg,
  output logic [WIDTH-1:0] y
);

  assign y = neg ? (~a + WIDTH'(1)) : a;

endmodule

// File: rtl/seq_mult.sv
// Multi-cycle shift-add multiplier with per-operation signed mode and valid/ready handshakes.
module seq_mult
  import mult_pkg::*;
#(
  parameter  int unsigned WIDTH = DefaultWidth,
  localparam int unsigned CNT_W = cnt_width(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   n1,
  input  logic [WIDTH-1:0]   n2,
  input  logic               is_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic               neg_q, neg_d;
  logic [2*WIDTH-1:0] result_q, result_d;

  logic [WIDTH-1:0]   mag1, mag2;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] acc_shift;
  logic [2*WIDTH-1:0] acc_signed;

  sign_mag #(.WIDTH(WIDTH)) u_abs1 (
    .a  (n1),
    .neg(is_signed & n1[WIDTH-1]),
    .y  (mag1)
  );

  sign_mag #(.WIDTH(WIDTH)) u_abs2 (
    .a  (n2),
    .neg(is_signed & n2[WIDTH-1]),
    .y  (mag2)
  );

  // Carry of the upper-half add becomes the new MSB after the right shift.
  assign sum       = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
  assign acc_shift = {sum, acc_q[WIDTH-1:1]};

  sign_mag #(.WIDTH(2 * WIDTH)) u_neg (
    .a  (acc_shift),
    .neg(neg_q),
    .y  (acc_signed)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    neg_d    = neg_q;
    result_d = result_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          mcand_d  = mag1;
          mplier_d = mag2;
          neg_d    = is_signed & (n1[WIDTH-1] ^ n2[WIDTH-1]);
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = StCalc;
        end
      end
      StCalc: begin
        acc_d    = acc_shift;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          result_d = acc_signed;
          state_d  = StDone;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      neg_q    <= neg_d;
      result_q <= result_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign result    = result_q;

endmodule
